seg_shift_out: RTL
==================

# seg_shift_out

Serializer downstream of the eight-digit segment pattern decoder. Captures the 64-bit active-low segment pattern on a start strobe and shifts it MSB-first into the board's external 8×74HC164 shift-register chain over a divided serial clock. Display output is blanked while shifting and re-enabled once the frame is complete. Sits between the pattern decoder and the top-level segment pins.

## Interface
Parameters:
- DIV, default 4: seg_clk half-period in clk cycles; legal range 1..255.
- WIDTH, default 64: frame length in bits; fixed at 64 for the board.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to send pattern; honoured only in IDLE.
- pattern  input  64  segment frame, bit 63 shifted first.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when the frame is latched onto the display.
- seg_clk  output  1  serial shift clock to the chain (data sampled on its rising edge).
- seg_sout  output  1  serial data.
- seg_pen  output  1  display output enable, active-high.
- seg_clrn  output  1  chain clear, active-low.

## Operation
- States: IDLE, SHIFT, LATCH. Reset enters IDLE.
- Reset values: busy=0, done=0, seg_clk=0, seg_sout=0, seg_pen=0, seg_clrn=0. seg_clrn goes 1 on the first clk edge after rst deasserts and stays 1.
- IDLE: on start=1, load pattern into a 64-bit shift register, clear bit counter to 0 and divider counter to 0, drive seg_pen=0, go SHIFT. start=0 or no change: hold outputs.
- SHIFT: per bit, seg_sout = shreg[63]; seg_clk low for DIV cycles then high for DIV cycles. At end of high phase: shift shreg left by one, increment bit counter. After bit 63's high phase, seg_clk returns 0, go LATCH.
- LATCH: one cycle; seg_pen=1, done=1, busy=0 next; return to IDLE.
- start while busy (SHIFT or LATCH): ignored, no queuing; pattern changes during SHIFT have no effect (frame captured at accept).
- seg_pen stays 1 in IDLE after the first completed frame; reset clears it.
- rst asserted mid-frame: immediate abort to reset values; partial frame is discarded (seg_clrn=0 clears the chain).

## Timing
- Accepted start at edge N: busy=1, seg_pen=0, seg_sout=pattern[63], seg_clk=0 visible after edge N.
- First seg_clk rising edge after edge N+DIV; bit k's rising edge after edge N+(2k+1)·DIV.
- SHIFT lasts 128·DIV cycles; done pulses in the cycle after edge N+128·DIV; total start-to-done 128·DIV+1 cycles.
- seg_sout changes only on seg_clk falling edges (setup and hold each ≥ DIV clk cycles).
- Earliest next accepted start: cycle after done (start coincident with done is ignored).
- Counters: bit counter 6 bits (wraps 63→0 exactly at SHIFT exit), divider counter 8 bits, compared against DIV-1.

## Structure
- Shared display package: state enum (IDLE, SHIFT, LATCH), WIDTH constant 64, DIV default.
- One sub-module natural: seg_clk_div (divider counter producing phase-end ticks and seg_clk level), enabled only in SHIFT.
- All outputs registered; no combinational paths from inputs to outputs.

## Test plan
- Reset: rst high for 3 cycles -> all outputs 0; one cycle after release seg_clrn=1, others 0.
- DIV=1, pattern=64'h8000_0000_0000_0001 -> bench shift-register model captures exactly 64'h8000_0000_0000_0001; first bit 1, bits 1..62 zero, last 1; done 129 cycles after start; seg_pen 0→1 with done.
- DIV=4, pattern=64'hFFC0_F9A4_B099_9282 -> 64 seg_clk rising edges, each period 8 cycles, captured frame equals pattern; seg_sout stable around every rising edge.
- start pulsed again at cycles 10 and 200 of a DIV=2 frame with different pattern -> ignored; captured frame equals original; only one done.
- rst asserted at bit 30 -> outputs reset immediately, seg_clrn=0; subsequent start sends full new frame correctly.
- Back-to-back: start in cycle after done with pattern 64'h0 -> second frame accepted, seg_pen drops to 0 during SHIFT, captured frame all zeros.

Source files
------------

// File: rtl/seg_shift_out_pkg.sv
// Shared definitions for the segment-pattern serializer: FSM states,
// frame length and default serial clock divider.
package seg_shift_out_pkg;

  localparam int WIDTH_C     = 64;
  localparam int DIV_DEFAULT = 4;
  localparam int BIT_CNT_W   = 6;
  localparam int DIV_CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

endpackage

// File: rtl/seg_shift_out_clk_div.sv
// Serial clock divider: DIV clk cycles per seg_clk phase, and a tick at
// the end of each high phase that marks one completed bit.
module seg_clk_div
  import seg_shift_out_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic seg_clk,
  output logic bit_end
);

  localparam logic [DIV_CNT_W-1:0] TERM = DIV_CNT_W'(DIV - 1);

  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic                 lvl_q, lvl_d;
  logic                 phase_end;

  always_comb begin
    phase_end = en && (cnt_q == TERM);
    cnt_d     = cnt_q;
    lvl_d     = lvl_q;
    if (clr) begin
      cnt_d = '0;
      lvl_d = 1'b0;
    end else if (en) begin
      if (phase_end) begin
        cnt_d = '0;
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign seg_clk = lvl_q;
  // A phase ending while the level is high is the falling edge: bit done.
  assign bit_end = phase_end & lvl_q;

endmodule

// File: rtl/seg_shift_out.sv
// Captures a 64-bit active-low segment frame on start and shifts it
// MSB-first into the external 74HC164 chain, blanking the display meanwhile.
module seg_shift_out
  import seg_shift_out_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int WIDTH = WIDTH_C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic             busy,
  output logic             done,
  output logic             seg_clk,
  output logic             seg_sout,
  output logic             seg_pen,
  output logic             seg_clrn
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pen_q, pen_d;
  logic                 clrn_q, clrn_d;
  logic                 div_en, div_clr, bit_end;

  seg_clk_div #(.DIV(DIV)) u_clk_div (
    .clk     (clk),
    .rst     (rst),
    .en      (div_en),
    .clr     (div_clr),
    .seg_clk (seg_clk),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pen_d     = pen_q;
    clrn_d    = 1'b1;
    div_en    = 1'b0;
    div_clr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d   = pattern;
          bit_cnt_d = '0;
          div_clr   = 1'b1;
          pen_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        div_en = 1'b1;
        if (bit_end) begin
          shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
          // Last bit clocked into the chain: latch it onto the display.
          if (bit_cnt_q == LAST_BIT) begin
            pen_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_LATCH;
          end
        end
      end
      ST_LATCH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pen_q     <= 1'b0;
      clrn_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pen_q     <= pen_d;
      clrn_q    <= clrn_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign seg_sout = shreg_q[WIDTH-1];
  assign seg_pen  = pen_q;
  assign seg_clrn = clrn_q;

endmodule
